register_file_mw_mr_be: RTL

- Parametrised latch-based register file: N_WRITE write ports, N_READ read ports, per-byte write enables.
- Adds a deterministic write-collision policy and a sequential hardware clear engine.
- Targets cluster-local scratch storage and core register files.
- Storage uses per-word gated-clock latches built from the existing cluster_clock_gating cell.

---
 rtl/register_file_pkg.sv | 23 ++
 rtl/cluster_clock_gating.sv | 18 +
 rtl/rf_write_stage.sv | 146 ++++++++++++++
 rtl/register_file_mw_mr_be.sv | 109 ++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared types and helpers for the multi-port latch register file.
// The byte-lane merge decides which write port owns each byte when ports collide.
package register_file_pkg;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_e;

  localparam int RF_DATA_WIDTH = 32;
  localparam int NB            = RF_DATA_WIDTH / 8;

  // Port 1 outranks port 0 on a shared address; port 0 keeps only the bytes port 1 leaves alone.
  function automatic logic [1:0] mergeByteLane(input logic [1:0] req,
                                               input logic [1:0] be,
                                               input logic       sameAddr);
    logic [1:0] eff;
    eff[1] = req[1] & be[1];
    eff[0] = req[0] & be[0] & ~(sameAddr & eff[1]);
    return eff;
  endfunction

endpackage

// File: rtl/cluster_clock_gating.sv
// Glitch-free clock gate: enable is captured while the clock is low.
// test_en_i forces the gate open for scan shifting.
module cluster_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic en_q;

  always_latch begin
    if (!clk_i) en_q = en_i | test_en_i;
  end

  assign clk_o = clk_i & en_q;

endmodule

// File: rtl/rf_write_stage.sv
// Write arbitration, byte merge, clear engine and write staging registers.
// Staged values drive the per-word latches during the high phase of the next cycle.
module rf_write_stage import register_file_pkg::*; #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_WRITE    = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                clkInt_i,
  input  logic                                clear_i,
  input  logic [N_WRITE-1:0]                  we_i,
  input  logic [N_WRITE*ADDR_WIDTH-1:0]       waddr_i,
  input  logic [N_WRITE*(DATA_WIDTH/8)-1:0]   wbe_i,
  input  logic [N_WRITE*DATA_WIDTH-1:0]       wdata_i,
  output logic                                busy_o,
  output logic                                wr_collision_o,
  output logic                                gateEn_o,
  output logic [(2**ADDR_WIDTH)-1:0]          wordEn_o,
  output logic [N_WRITE*(2**ADDR_WIDTH)-1:0]  wordOh_o,
  output logic [N_WRITE*(DATA_WIDTH/8)-1:0]   be_o,
  output logic [N_WRITE*DATA_WIDTH-1:0]       wdata_o
);

  localparam int NumWords = 2**ADDR_WIDTH;
  localparam int NumBytes = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] LastWord = (ADDR_WIDTH+1)'(NumWords - 1);

  rf_state_e state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic wrCollision_q;
  logic acceptWr;
  logic sameAddr;

  logic [1:0]            wrReq;
  logic [ADDR_WIDTH-1:0] wrAddr [2];
  logic [NumBytes-1:0]   wrBe   [2];
  logic [DATA_WIDTH-1:0] wrData [2];
  logic [NumBytes-1:0]   beEff  [2];
  logic [1:0]            lane;

  logic [1:0][NumWords-1:0]         wordOh_d;
  logic [N_WRITE-1:0][NumWords-1:0] wordOh_q;
  logic [N_WRITE-1:0][NumBytes-1:0] be_q;
  logic [N_WRITE-1:0][DATA_WIDTH-1:0] wdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RF_IDLE: begin
        if (clear_i) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
      RF_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastWord) state_d = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
  end

  assign busy_o   = (state_q == RF_CLEAR);
  assign acceptWr = (state_q == RF_IDLE) && !clear_i;

  // The clear engine borrows port 0 and locks out functional writes while it runs.
  always_comb begin
    wrReq = '0;
    for (int p = 0; p < 2; p++) begin
      wrAddr[p] = '0;
      wrBe[p]   = '0;
      wrData[p] = '0;
    end
    if (busy_o) begin
      wrReq[0]  = 1'b1;
      wrAddr[0] = cnt_q[ADDR_WIDTH-1:0];
      wrBe[0]   = '1;
    end else if (acceptWr) begin
      for (int p = 0; p < N_WRITE; p++) begin
        wrReq[p]  = we_i[p];
        wrAddr[p] = waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        wrBe[p]   = wbe_i[p*NumBytes +: NumBytes];
        wrData[p] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign sameAddr = wrReq[0] & wrReq[1] & (wrAddr[0] == wrAddr[1]);

  always_comb begin
    lane = '0;
    for (int p = 0; p < 2; p++) beEff[p] = '0;
    for (int b = 0; b < NumBytes; b++) begin
      lane        = mergeByteLane(wrReq, {wrBe[1][b], wrBe[0][b]}, sameAddr);
      beEff[0][b] = lane[0];
      beEff[1][b] = lane[1];
    end
  end

  always_comb begin
    wordOh_d = '0;
    for (int p = 0; p < 2; p++) begin
      for (int w = 0; w < NumWords; w++) begin
        wordOh_d[p][w] = wrReq[p] && (wrAddr[p] == ADDR_WIDTH'(w));
      end
    end
  end

  assign wordEn_o = wordOh_d[0] | wordOh_d[1];
  assign gateEn_o = |wrReq;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RF_IDLE;
      cnt_q         <= '0;
      wrCollision_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wrCollision_q <= sameAddr;
    end
  end

  // Staging only ticks on the gated clock, so idle cycles leave it untouched.
  always_ff @(posedge clkInt_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wordOh_q <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      for (int p = 0; p < N_WRITE; p++) begin
        wordOh_q[p] <= wordOh_d[p];
        be_q[p]     <= beEff[p];
        wdata_q[p]  <= wrData[p];
      end
    end
  end

  assign wr_collision_o = wrCollision_q;
  assign wordOh_o       = wordOh_q;
  assign be_o           = be_q;
  assign wdata_o        = wdata_q;

endmodule

// File: rtl/register_file_mw_mr_be.sv
// Latch-based register file with N_WRITE byte-enabled write ports and N_READ read ports.
// Each word is a latch bank opened by its own gated clock during the high phase.
module register_file_mw_mr_be import register_file_pkg::*; #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = NB * 8,
  parameter int N_READ     = 2,
  parameter int N_WRITE    = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               test_en_i,
  input  logic                               clear_i,
  output logic                               busy_o,
  output logic                               wr_collision_o,
  input  logic [N_READ-1:0]                  ReadEnable,
  input  logic [N_READ*ADDR_WIDTH-1:0]       ReadAddr,
  output logic [N_READ*DATA_WIDTH-1:0]       ReadData,
  input  logic [N_WRITE-1:0]                 WriteEnable,
  input  logic [N_WRITE*ADDR_WIDTH-1:0]      WriteAddr,
  input  logic [N_WRITE*(DATA_WIDTH/8)-1:0]  WriteBE,
  input  logic [N_WRITE*DATA_WIDTH-1:0]      WriteData
);

  localparam int NumWords = 2**ADDR_WIDTH;
  localparam int NumBytes = DATA_WIDTH / 8;

  logic clkInt;
  logic gateEn;
  logic [NumWords-1:0]            wordEn;
  logic [N_WRITE*NumWords-1:0]    wordOh;
  logic [N_WRITE*NumBytes-1:0]    stagedBe;
  logic [N_WRITE*DATA_WIDTH-1:0]  stagedData;
  logic [DATA_WIDTH-1:0]          mem [NumWords];
  logic [N_READ-1:0][ADDR_WIDTH-1:0] raddr_q;

  rf_write_stage #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .N_WRITE    (N_WRITE)
  ) uWriteStage (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clkInt_i       (clkInt),
    .clear_i        (clear_i),
    .we_i           (WriteEnable),
    .waddr_i        (WriteAddr),
    .wbe_i          (WriteBE),
    .wdata_i        (WriteData),
    .busy_o         (busy_o),
    .wr_collision_o (wr_collision_o),
    .gateEn_o       (gateEn),
    .wordEn_o       (wordEn),
    .wordOh_o       (wordOh),
    .be_o           (stagedBe),
    .wdata_o        (stagedData)
  );

  cluster_clock_gating uGlobalGate (
    .clk_i     (clk),
    .en_i      (gateEn),
    .test_en_i (test_en_i),
    .clk_o     (clkInt)
  );

  for (genvar w = 0; w < NumWords; w++) begin : gWord
    logic wordClk;
    logic [DATA_WIDTH-1:0] word_q;

    cluster_clock_gating uWordGate (
      .clk_i     (clkInt),
      .en_i      (wordEn[w]),
      .test_en_i (test_en_i),
      .clk_o     (wordClk)
    );

    always_latch begin
      if (wordClk) begin
        for (int b = 0; b < NumBytes; b++) begin
          for (int p = 0; p < N_WRITE; p++) begin
            if (wordOh[p*NumWords + w] && stagedBe[p*NumBytes + b]) begin
              word_q[b*8 +: 8] = stagedData[p*DATA_WIDTH + b*8 +: 8];
            end
          end
        end
      end
    end

    assign mem[w] = word_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q <= '0;
    end else begin
      for (int z = 0; z < N_READ; z++) begin
        if (ReadEnable[z]) raddr_q[z] <= ReadAddr[z*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Reads are combinational from the latches, so a same-edge write is visible immediately.
  always_comb begin
    ReadData = '0;
    for (int z = 0; z < N_READ; z++) begin
      ReadData[z*DATA_WIDTH +: DATA_WIDTH] = mem[raddr_q[z]];
    end
  end

endmodule
